// File: rtl/load_store_unit_if.sv
// Request/response and word-memory port bundle for the load/store unit.
// The master side is the unit itself; the slave side is the pipeline plus memory.
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: sub-word lane select, sign/zero extension and
// read-modify-write of sub-word stores onto a word-only memory port.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               reset,
  load_store_unit_if.master bus
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [1:0]  off;
  logic [15:0] wdata;

  function automatic logic misaligned(input logic [2:0] o, input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (o == OP_LW || o == OP_SW) m = (a != 2'b00);
    else if (o == OP_LH || o == OP_LHU || o == OP_SH) m = a[0];
    return m;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] o, input logic [1:0] k,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{k, 3'b000} +: 8];
    h = w[{k[1], 4'b0000} +: 16];
    case (o)
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      default: r = w;
    endcase
    return r;
  endfunction

  // Only the addressed lane is replaced; the rest of the fetched word is kept.
  function automatic logic [31:0] merge(input logic [2:0] o, input logic [1:0] k,
                                        input logic [31:0] w, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (o == OP_SH) m[{k[1], 4'b0000} +: 16] = d;
    else            m[{k, 3'b000} +: 8]      = d[7:0];
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      op             <= '0;
      off            <= '0;
      wdata          <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.mem_read   <= 1'b0;
      bus.mem_write  <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          op            <= bus.req_op;
          off           <= bus.req_addr[1:0];
          wdata         <= bus.req_wdata[15:0];
          bus.req_ready <= 1'b0;
          if (misaligned(bus.req_op, bus.req_addr[1:0])) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
          end else begin
            bus.mem_addr <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (bus.req_op <= OP_LBU) begin
              state        <= LOAD;
              bus.mem_read <= 1'b1;
            end else if (bus.req_op == OP_SW) begin
              state         <= WRITE;
              bus.mem_write <= 1'b1;
              bus.mem_wdata <= bus.req_wdata;
            end else begin
              state        <= RMW_READ;
              bus.mem_read <= 1'b1;
            end
          end
        end
        LOAD: begin
          bus.resp_rdata <= extract(op, off, bus.mem_rdata);
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RMW_READ: begin
          bus.mem_wdata <= merge(op, off, bus.mem_rdata, wdata);
          bus.mem_write <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage initiator for the word-organised data memory. Accepts one load/store request at a time from the pipeline and drives the memory's word-only read/write port. Handles byte/halfword lane selection, sign/zero extension and read-modify-write for sub-word stores. Flags misaligned accesses without touching memory.

## Interface

- ADDR_W, 32, byte-address width of requests and memory port.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, 101 sw, 110 sh, 111 sb.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sh uses [15:0], sb uses [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; 1 = misaligned, no memory access made.
- resp_rdata  out  32  extended load data; held until the next accepted request.
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  full word to write.
- mem_read  out  1  read strobe; memory read is combinational.
- mem_write  out  1  write strobe; held for one full cycle.
- mem_rdata  in  32  read word, valid in the same cycle as mem_read.

## Operation

- Byte lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; halfword h = addr[1], bits [16h+15:16h].
- lh/lb sign-extend; lhu/lbu zero-extend; lw passes the word through.
- Alignment: lw/sw need addr[1:0]=00; lh/lhu/sh need addr[0]=0; bytes are always aligned.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid, latch op, addr and wdata, then transition:
  - misaligned -> RESP with err=1;
  - load ops -> LOAD;
  - sw -> WRITE, with merged word = wdata;
  - sh/sb -> RMW_READ.
- LOAD: mem_read=1. Capture the extracted, extended value into resp_rdata. Next state RESP.
- RMW_READ: mem_read=1. Capture mem_rdata with the target lane replaced by store data; other lanes are unchanged. Next state WRITE.
- WRITE: mem_write=1, mem_wdata = merged word. Next state RESP.
- RESP: resp_valid=1 for one cycle; resp_err reflects the latched error. Next state IDLE.
- Strobe and address outputs:
  - mem_read, mem_write, mem_addr and mem_wdata are decoded from the registered state and latched fields only. No combinational path from req_* to mem_*.
  - mem_read and mem_write are never high together.
  - Outside LOAD/RMW_READ/WRITE, mem_read=mem_write=0; mem_addr and mem_wdata hold their last values.
- Stores and errors leave resp_rdata unchanged.

## Timing

- Cycle 0 = the edge where req_valid && req_ready is sampled.
- Latency from cycle 0 to the resp_valid cycle:
  - misaligned: 1;
  - load: 2 (mem_read in cycle 1);
  - sw: 2 (mem_write in cycle 1);
  - sh/sb: 3 (mem_read in cycle 1, mem_write in cycle 2).
- Throughput: the next request is accepted in the cycle after RESP at the earliest. A request held during the busy period is not sampled until req_ready=1.
- Reset values: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. req_ready=1 from the first cycle after reset.
- Reset mid-operation:
  - the FSM returns to IDLE on that edge;
  - any pending strobe drops and no resp_valid is produced;
  - reset in RMW_READ means no write occurs;
  - reset asserted in WRITE does not cancel the write already strobed in that cycle.
- req_valid arriving in the same cycle as reset is ignored.

## Test plan

- Preload word 0x10 = 0x8899AABB. lb 0x11 -> resp_rdata 0xFFFFFFAA two cycles after accept. lbu 0x11 -> 0x000000AA. lw 0x10 -> 0x8899AABB. Each case: mem_addr=0x10 and mem_read for exactly one cycle.
- lh 0x12 -> 0xFFFF8899; lhu 0x12 -> 0x00008899; lh 0x10 -> 0xFFFFAABB.
- sb 0x13 with wdata 0x12345677 -> memory 0x10 = 0x7799AABB. Sequence: mem_read in cycle 1, mem_write in cycle 2, resp_valid in cycle 3, err=0.
- sh 0x10 with wdata 0xDEADBEEF -> memory = 0x8899BEEF. sw 0x10 with 0xCAFEF00D -> memory = 0xCAFEF00D, with no mem_read.
- sh 0x11, lw 0x12 and sw 0x13 -> resp_err=1 in cycle 1 for each. mem_read and mem_write stay 0 and the memory is unchanged.
- Reset asserted in RMW_READ during an sb -> no mem_write, no resp_valid, req_ready=1 the next cycle. A following lw 0x10 returns the unmodified word.
